// File: rtl/morse_play_ctrl.sv
// Plays a fixed Morse message on the LED. Slow and fast button releases share a
// single player. A request that arrives while a run is in progress is queued one deep.
module morse_play_ctrl #(
  parameter int unsigned SLOW_UNIT = 50000000,
  parameter int unsigned FAST_UNIT = 12500000,
  parameter int unsigned MSG_LEN = 8,
  parameter logic [MSG_LEN-1:0] MSG_PATTERN = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic slow_button,
  input  logic fast_button,
  output logic LED,
  output logic busy,
  output logic rate_sel,
  output logic done
);

  localparam int unsigned MAX_UNIT = (SLOW_UNIT > FAST_UNIT) ? SLOW_UNIT : FAST_UNIT;
  localparam int unsigned CNT_W = $clog2(64'(3) * 64'(MAX_UNIT) + 64'(1));
  localparam int unsigned IDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

  localparam logic [CNT_W-1:0] SLOW_1 = CNT_W'(SLOW_UNIT - 1);
  localparam logic [CNT_W-1:0] SLOW_3 = CNT_W'(3 * SLOW_UNIT - 1);
  localparam logic [CNT_W-1:0] FAST_1 = CNT_W'(FAST_UNIT - 1);
  localparam logic [CNT_W-1:0] FAST_3 = CNT_W'(3 * FAST_UNIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);

  typedef enum logic [1:0] {IDLE, MARK, SPACE, TAIL} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [IDX_W-1:0] idx, idx_d;
  logic             rate_d;
  logic             pending, pend_d;
  logic             pending_fast, pend_fast_d;
  logic             slow_ff, fast_ff;
  logic             req_slow, req_fast;
  logic             req_any;
  logic             done_d;
  logic             start, start_fast;

  // The counter is loaded with (duration - 1) and counts down to zero.
  function automatic logic [CNT_W-1:0] unit1(input logic fast);
    return fast ? FAST_1 : SLOW_1;
  endfunction

  function automatic logic [CNT_W-1:0] unit3(input logic fast);
    return fast ? FAST_3 : SLOW_3;
  endfunction

  // A request is a one-cycle pulse on the button release (1 -> 0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slow_ff  <= 1'b0;
      fast_ff  <= 1'b0;
      req_slow <= 1'b0;
      req_fast <= 1'b0;
    end else begin
      slow_ff  <= slow_button;
      fast_ff  <= fast_button;
      req_slow <= slow_ff & ~slow_button;
      req_fast <= fast_ff & ~fast_button;
    end
  end

  assign req_any = req_slow | req_fast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      rate_sel     <= 1'b0;
      pending      <= 1'b0;
      pending_fast <= 1'b0;
      LED          <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      idx          <= idx_d;
      rate_sel     <= rate_d;
      pending      <= pend_d;
      pending_fast <= pend_fast_d;
      LED          <= (state_d == MARK);
      busy         <= (state_d != IDLE);
      done         <= done_d;
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    idx_d       = idx;
    rate_d      = rate_sel;
    pend_d      = pending;
    pend_fast_d = pending_fast;
    done_d      = 1'b0;
    start       = 1'b0;
    start_fast  = 1'b0;

    // Requests during a run collapse into one pending entry; fast is sticky.
    if (state != IDLE && req_any) begin
      pend_d      = 1'b1;
      pend_fast_d = pending_fast | req_fast;
    end

    case (state)
      IDLE: begin
        if (req_any) begin
          start      = 1'b1;
          start_fast = req_fast;
        end
      end
      MARK: begin
        if (cnt == '0) begin
          if (idx == LAST_IDX) begin
            state_d = TAIL;
            cnt_d   = unit3(rate_sel);
          end else begin
            state_d = SPACE;
            cnt_d   = unit1(rate_sel);
          end
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      SPACE: begin
        if (cnt == '0) begin
          idx_d   = idx + IDX_W'(1);
          state_d = MARK;
          cnt_d   = MSG_PATTERN[idx_d] ? unit3(rate_sel) : unit1(rate_sel);
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      TAIL: begin
        if (cnt == '0) begin
          done_d = 1'b1;
          // pend_d already includes a request that arrives in this final cycle.
          if (pend_d) begin
            start      = 1'b1;
            start_fast = pend_fast_d;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d     = MARK;
      idx_d       = '0;
      rate_d      = start_fast;
      cnt_d       = MSG_PATTERN[0] ? unit3(start_fast) : unit1(start_fast);
      pend_d      = 1'b0;
      pend_fast_d = 1'b0;
    end
  end

endmodule
